// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WB over a shared
// datapath and guards wait-stated memory accesses with a timeout abort.
module mc_control #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [4:0] alu_control,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPE_EX, ALU_WB, BEQ, IMM_EX, IMM_WB, JUMP
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic       in_mem;
  logic       timeout;
  logic       set_illegal;
  logic       req_raw;
  logic       write_raw;
  logic       ir_raw;
  logic       pc_write;
  logic       branch;
  logic       reg_write_raw;

  // Timeout fires in the last allowed request cycle unless mem_ready completes it.
  assign in_mem  = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign timeout = in_mem && !mem_ready && (wait_cnt == TIMEOUT_LAST);

  // Next-state selection and illegal-instruction detection.
  always_comb begin
    state_next  = state;
    set_illegal = 1'b0;
    case (state)
      FETCH: begin
        if (mem_ready) state_next = DECODE;
        else           state_next = FETCH;
      end
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:            state_next = MEMADR;
          OP_R:                    state_next = RTYPE_EX;
          OP_BEQ:                  state_next = BEQ;
          OP_ADDI, OP_ANDI, OP_ORI: state_next = IMM_EX;
          OP_J:                    state_next = JUMP;
          default: begin
            set_illegal = 1'b1;
            state_next  = FETCH;
          end
        endcase
      end
      MEMADR: begin
        if (opcode == OP_SW) state_next = MEMWR;
        else                 state_next = MEMRD;
      end
      MEMRD: begin
        if (mem_ready)    state_next = MEMWB;
        else if (timeout) state_next = FETCH;
        else              state_next = MEMRD;
      end
      MEMWR: begin
        if (mem_ready || timeout) state_next = FETCH;
        else                      state_next = MEMWR;
      end
      RTYPE_EX: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR: state_next = ALU_WB;
          default: begin
            set_illegal = 1'b1;
            state_next  = FETCH;
          end
        endcase
      end
      IMM_EX:  state_next = IMM_WB;
      default: state_next = FETCH;
    endcase
  end

  // Datapath controls decoded from the current state.
  always_comb begin
    req_raw       = 1'b0;
    write_raw     = 1'b0;
    i_or_d        = 1'b0;
    ir_raw        = 1'b0;
    pc_write      = 1'b0;
    branch        = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ext_zero      = 1'b0;
    alu_control   = ALU_AND;
    reg_write_raw = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    case (state)
      FETCH: begin
        req_raw     = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        ir_raw      = mem_ready;
        pc_write    = mem_ready;
      end
      DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
      end
      MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
      end
      MEMRD: begin
        req_raw = 1'b1;
        i_or_d  = 1'b1;
      end
      MEMWB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
      end
      MEMWR: begin
        req_raw   = 1'b1;
        write_raw = 1'b1;
        i_or_d    = 1'b1;
      end
      RTYPE_EX: begin
        alu_src_a = 1'b1;
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      ALU_WB: begin
        reg_write_raw = 1'b1;
        reg_dst       = 1'b1;
      end
      BEQ: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        branch      = 1'b1;
        pc_src      = 2'b01;
      end
      IMM_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          OP_ANDI: begin
            alu_control = ALU_AND;
            ext_zero    = 1'b1;
          end
          OP_ORI: begin
            alu_control = ALU_OR;
            ext_zero    = 1'b1;
          end
          default: alu_control = ALU_ADD;
        endcase
      end
      IMM_WB: reg_write_raw = 1'b1;
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      default: req_raw = 1'b0;
    endcase
  end

  // Strobes are forced low while reset is held, even though reset already selects FETCH.
  assign mem_req   = req_raw & ~reset;
  assign mem_write = write_raw & ~reset;
  assign ir_write  = ir_raw & ~reset;
  assign pc_en     = (pc_write | (branch & zero)) & ~reset;
  assign reg_write = reg_write_raw & ~reset;

  // State register, wait counter and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      wait_cnt    <= 8'd0;
      illegal_op  <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_next;
      if (set_illegal) illegal_op  <= 1'b1;
      if (timeout)     mem_timeout <= 1'b1;
      // A fetch retry stays in FETCH, so the timeout itself must also clear the count.
      if (timeout || mem_ready || (state_next != state)) wait_cnt <= 8'd0;
      else if (in_mem)                                    wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule
